ula_seq: RTL and testbench

Parametrised, registered successor to the team's combinational 4-op ALU. Keeps opcodes 00–11 (AND/OR/ADD/SUB) bit-compatible and adds XOR, SLT and a multi-cycle signed shift-add multiplier. Adds a start/busy/done handshake and a full flag set (overflow, carry, zero, negative). Sits between the lab datapath register file and the result register / 7-segment display logic.

---
 rtl/ula_seq.sv | 143 ++++++++++++++
 tb/tb_ula_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// Registered ALU. AND/OR/ADD/SUB/XOR/SLT/NOP finish in one cycle. MUL is a
// signed shift-add over magnitudes that takes N_BITS cycles and reports through start/busy/done.
module ula_seq #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result,
  output logic              flag_ovf,
  output logic              flag_carry,
  output logic              flag_zero,
  output logic              flag_neg,
  output logic              dbg_state
);
  localparam int W2 = 2 * N_BITS;
  localparam int CW = $clog2(N_BITS);
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);
  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                         OP_SUB = 3'b011, OP_XOR = 3'b100, OP_SLT = 3'b101,
                         OP_MUL = 3'b110;

  typedef enum logic {S_IDLE = 1'b0, S_MUL_RUN = 1'b1} state_t;

  // Handshake: a request is taken on the rising edge where start=1 and busy=0.
  // done pulses for one cycle when result and the flags change.
  // A start seen while busy=1 is dropped.
  state_t              r_state;
  logic                r_busy, r_done, r_ovf, r_carry, r_zero, r_neg, r_sign;
  logic [N_BITS-1:0]   r_result, r_ma, r_mb;
  logic [W2-1:0]       r_acc;
  logic [CW-1:0]       r_cnt;

  logic [N_BITS:0]     w_sum, w_diff;
  logic [N_BITS-1:0]   w_res, w_abs_a, w_abs_b;
  logic                w_ovf, w_carry, w_mul_ovf;
  logic [W2-1:0]       w_step, w_acc_next, w_prod;

  always_comb begin
    w_sum   = {1'b0, a} + {1'b0, b};
    w_diff  = {1'b0, a} + {1'b0, ~b} + (N_BITS+1)'(1);
    w_abs_a = a[N_BITS-1] ? (~a + N_BITS'(1)) : a;
    w_abs_b = b[N_BITS-1] ? (~b + N_BITS'(1)) : b;
    w_res   = '0;
    w_ovf   = 1'b0;
    w_carry = 1'b0;
    case (op)
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_ADD: begin
        w_res   = w_sum[N_BITS-1:0];
        w_carry = w_sum[N_BITS];
        w_ovf   = (a[N_BITS-1] == b[N_BITS-1]) && (w_res[N_BITS-1] != a[N_BITS-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[N_BITS-1:0];
        w_carry = w_diff[N_BITS];
        w_ovf   = (a[N_BITS-1] != b[N_BITS-1]) && (w_res[N_BITS-1] != a[N_BITS-1]);
      end
      OP_XOR: w_res = a ^ b;
      OP_SLT: w_res = {{(N_BITS-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_res = '0;
    endcase

    // The last shift-add step feeds the sign fix-up directly, so the final edge also registers the result.
    w_step     = r_mb[r_cnt] ? (W2'(r_ma) << r_cnt) : '0;
    w_acc_next = r_acc + w_step;
    w_prod     = r_sign ? (~w_acc_next + W2'(1)) : w_acc_next;
    w_mul_ovf  = !((&w_prod[W2-1:N_BITS-1]) || !(|w_prod[W2-1:N_BITS-1]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_sign   <= 1'b0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              r_ma    <= w_abs_a;
              r_mb    <= w_abs_b;
              r_sign  <= a[N_BITS-1] ^ b[N_BITS-1];
              r_acc   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_MUL_RUN;
            end else begin
              r_result <= w_res;
              r_ovf    <= w_ovf;
              r_carry  <= w_carry;
              r_zero   <= (w_res == '0);
              r_neg    <= w_res[N_BITS-1];
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL_RUN: begin
          if (r_cnt == LAST) begin
            r_result <= w_prod[N_BITS-1:0];
            r_ovf    <= w_mul_ovf;
            r_carry  <= 1'b0;
            r_zero   <= (w_prod[N_BITS-1:0] == '0);
            r_neg    <= w_prod[N_BITS-1];
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign flag_ovf   = r_ovf;
  assign flag_carry = r_carry;
  assign flag_zero  = r_zero;
  assign flag_neg   = r_neg;
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq with N_BITS=8. It applies a table of directed vectors, then hand-written
// handshake/abort sequences, then random ops checked against an arithmetic reference model.
module tb_ula_seq;
  localparam int N = 8;
  localparam int W = 12;  // {result, ovf, carry, zero, neg}
  localparam logic [2:0] ADD = 3'b010, MUL = 3'b110;

  logic         clk, rst_n, start;
  logic [2:0]   op;
  logic [N-1:0] a, b;
  logic         busy, done, flag_ovf, flag_carry, flag_zero, flag_neg, dbg_state;
  logic [N-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  logic [W-1:0] exp_q[$];

  ula_seq #(.N_BITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flag_ovf(flag_ovf),
    .flag_carry(flag_carry), .flag_zero(flag_zero), .flag_neg(flag_neg),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic with range tests.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    int sx, sy, ux, uy, full;
    logic [N-1:0] r;
    logic ovf, carry;
    sx = int'($signed(x)); sy = int'($signed(y));
    ux = int'(x);          uy = int'(y);
    full = 0; ovf = 1'b0; carry = 1'b0; r = '0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin full = sx + sy; r = full[N-1:0]; ovf = (full > 127) || (full < -128); carry = (ux + uy) > 255; end
      3'b011: begin full = sx - sy; r = full[N-1:0]; ovf = (full > 127) || (full < -128); carry = (ux >= uy); end
      3'b100: r = x ^ y;
      3'b101: r = (sx < sy) ? 8'd1 : 8'd0;
      3'b110: begin full = sx * sy; r = full[N-1:0]; ovf = (full > 127) || (full < -128); end
      default: r = '0;
    endcase
    return {r, ovf, carry, (r == 0), r[N-1]};
  endfunction

  // scoreboard: every done pops one expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
      else chk("done_result", {20'd0, result, flag_ovf, flag_carry, flag_zero, flag_neg}, {20'd0, exp_q.pop_front()});
    end
  end

  // driver: accept one op, scramble inputs, then check latency, busy and done width
  task automatic run_op(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y, input logic [W-1:0] e);
    int lat, bcnt;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      bcnt += int'(busy);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (o == MUL) ? N + 1 : 1);
    chk("busy_cycles", bcnt, (o == MUL) ? N : 0);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic [N-1:0] res;
    logic         ovf, carry, zero, neg;
  } vec_t;

  vec_t vt[15];

  initial begin
    int lat, d0;
    logic [N-1:0] ra, rb;

    vt[0]  = '{3'b010, 8'd100, 8'd50,  8'h96, 1, 0, 0, 1};
    vt[1]  = '{3'b011, 8'h80,  8'h01,  8'h7F, 1, 1, 0, 0};
    vt[2]  = '{3'b011, 8'h03,  8'h05,  8'hFE, 0, 0, 0, 1};
    vt[3]  = '{3'b000, 8'hF0,  8'h0F,  8'h00, 0, 0, 1, 0};
    vt[4]  = '{3'b101, 8'hFE,  8'h01,  8'h01, 0, 0, 0, 0};
    vt[5]  = '{3'b110, 8'h0C,  8'hF6,  8'h88, 0, 0, 0, 1};
    vt[6]  = '{3'b110, 8'h80,  8'hFF,  8'h80, 1, 0, 0, 1};
    vt[7]  = '{3'b001, 8'hA5,  8'h0F,  8'hAF, 0, 0, 0, 1};
    vt[8]  = '{3'b100, 8'hA5,  8'hA5,  8'h00, 0, 0, 1, 0};
    vt[9]  = '{3'b111, 8'h12,  8'h34,  8'h00, 0, 0, 1, 0};
    vt[10] = '{3'b010, 8'hFF,  8'h01,  8'h00, 0, 1, 1, 0};
    vt[11] = '{3'b101, 8'h01,  8'hFE,  8'h00, 0, 0, 1, 0};
    vt[12] = '{3'b110, 8'h7F,  8'h7F,  8'h01, 1, 0, 0, 0};
    vt[13] = '{3'b110, 8'h80,  8'h80,  8'h00, 1, 0, 1, 0};
    vt[14] = '{3'b011, 8'h00,  8'h00,  8'h00, 0, 1, 1, 0};

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {20'd0, busy, done, dbg_state, flag_ovf, flag_carry, flag_zero, flag_neg, result}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_release_idle", {29'd0, busy, done, dbg_state}, 32'd0);

    // directed table
    for (int i = 0; i < 15; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, {vt[i].res, vt[i].ovf, vt[i].carry, vt[i].zero, vt[i].neg});

    // start during MUL is ignored; start in the done cycle is accepted
    d0 = n_done;
    exp_q.push_back(model(MUL, 8'h0C, 8'hF6));
    @(negedge clk);
    start = 1'b1; op = MUL; a = 8'h0C; b = 8'hF6;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 3) begin start = 1'b1; op = ADD; a = 8'd1; b = 8'd1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("ignored_start_latency", lat, N + 1);
    exp_q.push_back(model(ADD, 8'd3, 8'd4));
    start = 1'b1; op = ADD; a = 8'd3; b = 8'd4;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("dones_issued", n_done - d0, 2);
    chk("queue_drained", exp_q.size(), 0);

    // asynchronous reset in the middle of a MUL
    @(negedge clk);
    start = 1'b1; op = MUL; a = 8'h0C; b = 8'hF6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mul_running", {30'd0, busy, dbg_state}, 32'd3);
    #2 rst_n = 1'b0;
    #1 chk("abort_clears", {20'd0, busy, done, dbg_state, flag_ovf, flag_carry, flag_zero, flag_neg, result}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = n_done;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", n_done - d0, 0);
    run_op(ADD, 8'd100, 8'd50, model(ADD, 8'd100, 8'd50));

    // random ops against the reference model, with edge operands mixed in
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 8'h80; 1: ra = 8'h7F; 2: ra = 8'hFF; default: ra = 8'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rb = 8'h80; 1: rb = 8'h00; 2: rb = 8'h01; default: rb = 8'($urandom);
      endcase
      op = 3'($urandom_range(0, 7));
      run_op(op, ra, rb, model(op, ra, rb));
    end
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
